// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port memory between the CPU (port C) and the loader/debug
//   port (port L). Each granted access runs for MEM_LAT ACCESS cycles, then
//   one DONE cycle in which the owner's ack pulses. Port C has fixed priority.
//   Port L is guaranteed a grant once port C has won CPU_BURST_MAX grants in a
//   row while ld_req was pending.
//
// Ports
//   CLK, Reset                          clock, synchronous active-low reset
//   cpu_req/we/addr/wdata               port C request, held until cpu_ack
//   cpu_rdata, cpu_ack                  port C read data (registered), ack pulse
//   ld_req/we/addr/wdata                port L request, held until ld_ack
//   ld_rdata, ld_ack                    port L read data (registered), ack pulse
//   mem_addr, mem_wdata, mem_we, mem_re memory macro interface
//   mem_rdata                           memory read data, valid in last ACCESS cycle
//   owner                               00 none, 01 port C, 10 port L
module mem_port_arbiter #(
    parameter int AW            = 16,
    parameter int DW            = 16,
    parameter int MEM_LAT       = 2,
    parameter int CPU_BURST_MAX = 4
) (
    input  logic          CLK,
    input  logic          Reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ack,
    input  logic          ld_req,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_wdata,
    output logic [DW-1:0] ld_rdata,
    output logic          ld_ack,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    output logic          mem_re,
    input  logic [DW-1:0] mem_rdata,
    output logic [1:0]    owner
);

    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int BW = $clog2(CPU_BURST_MAX + 1);

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_C    = 2'b01;
    localparam logic [1:0] OWN_L    = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] wait_cnt;
    logic [BW-1:0] burst_cnt;
    logic          lat_we;
    logic          grant_c;
    logic          grant_l;
    logic          last_access;
    logic          burst_full;

    assign last_access = (wait_cnt == CW'(MEM_LAT - 1));
    assign burst_full  = (burst_cnt == BW'(CPU_BURST_MAX));

    // State register.
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Arbitration, next state and memory strobes. The write strobe is limited
    // to the first ACCESS cycle so each write hits the macro exactly once.
    always_comb begin
        state_next = state;
        grant_c    = 1'b0;
        grant_l    = 1'b0;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        cpu_ack    = 1'b0;
        ld_ack     = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_req && ld_req && burst_full) begin
                    grant_l = 1'b1;
                end else if (cpu_req) begin
                    grant_c = 1'b1;
                end else if (ld_req) begin
                    grant_l = 1'b1;
                end
                if (grant_c || grant_l) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                mem_re = !lat_we;
                mem_we = lat_we && (wait_cnt == '0);
                if (last_access) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                cpu_ack    = (owner == OWN_C);
                ld_ack     = (owner == OWN_L);
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Request latching, access timing, burst accounting and read capture.
    // The burst counter only counts C grants that actually made L wait.
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            wait_cnt  <= '0;
            burst_cnt <= '0;
            owner     <= OWN_NONE;
            lat_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_rdata <= '0;
            ld_rdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    wait_cnt <= '0;
                    if (grant_c) begin
                        owner     <= OWN_C;
                        lat_we    <= cpu_we;
                        mem_addr  <= cpu_addr;
                        mem_wdata <= cpu_wdata;
                        if (!ld_req) begin
                            burst_cnt <= '0;
                        end else if (!burst_full) begin
                            burst_cnt <= burst_cnt + 1'b1;
                        end
                    end else if (grant_l) begin
                        owner     <= OWN_L;
                        lat_we    <= ld_we;
                        mem_addr  <= ld_addr;
                        mem_wdata <= ld_wdata;
                        burst_cnt <= '0;
                    end else if (!ld_req) begin
                        burst_cnt <= '0;
                    end
                end
                ACCESS: begin
                    if (!last_access) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end else if (!lat_we) begin
                        if (owner == OWN_C) begin
                            cpu_rdata <= mem_rdata;
                        end else begin
                            ld_rdata <= mem_rdata;
                        end
                    end
                end
                DONE: begin
                    owner    <= OWN_NONE;
                    wait_cnt <= '0;
                end
                default: begin
                    owner <= OWN_NONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Self-checking bench for mem_port_arbiter. A small behavioural memory macro
//   answers the DUT's memory port; a reference memory and arbitration rules
//   kept in the bench predict latency, grant order and read data.
//
// Ports
//   none (top-level bench)
module tb_mem_port_arbiter;

    localparam int AW            = 16;
    localparam int DW            = 16;
    localparam int MEM_LAT       = 2;
    localparam int CPU_BURST_MAX = 4;
    localparam int ACK_BOUND     = 40;

    logic          CLK;
    logic          Reset;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_ack;
    logic          ld_req;
    logic          ld_we;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_wdata;
    logic [DW-1:0] ld_rdata;
    logic          ld_ack;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic          mem_re;
    logic [DW-1:0] mem_rdata;
    logic [1:0]    owner;

    int total;
    int bad;

    // Memory macro: untouched locations return a fixed address-derived pattern.
    logic [DW-1:0] macro [0:255];
    bit            written [0:255];
    logic [DW-1:0] ref_mem [0:255];

    // Monitor state, written only by the monitor process.
    int            we_cnt;
    int            re_cnt;
    int            cack_cnt;
    int            lack_cnt;
    logic [AW-1:0] last_we_addr;
    logic [DW-1:0] last_we_data;
    bit            ack_ld_q [$];
    logic [1:0]    ack_owner_q [$];

    mem_port_arbiter #(
        .AW(AW), .DW(DW), .MEM_LAT(MEM_LAT), .CPU_BURST_MAX(CPU_BURST_MAX)
    ) dut (
        .CLK(CLK), .Reset(Reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_rdata(ld_rdata), .ld_ack(ld_ack),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata), .owner(owner)
    );

    function automatic logic [DW-1:0] init_val(input int a);
        if (a == 16) return 16'h1234;
        return DW'((a * 40503) ^ 16'hC3A5) | 16'h0001;
    endfunction

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) begin
        if (mem_we) begin
            macro[mem_addr[7:0]]   <= mem_wdata;
            written[mem_addr[7:0]] <= 1'b1;
        end
    end

    assign mem_rdata = !mem_re ? '0 :
                       (written[mem_addr[7:0]] ? macro[mem_addr[7:0]] : init_val(int'(mem_addr[7:0])));

    always @(negedge CLK) begin
        if (mem_we) begin
            we_cnt       <= we_cnt + 1;
            last_we_addr <= mem_addr;
            last_we_data <= mem_wdata;
        end
        if (mem_re) re_cnt <= re_cnt + 1;
        if (cpu_ack) begin
            cack_cnt <= cack_cnt + 1;
            ack_ld_q.push_back(1'b0);
            ack_owner_q.push_back(owner);
        end
        if (ld_ack) begin
            lack_cnt <= lack_cnt + 1;
            ack_ld_q.push_back(1'b1);
            ack_owner_q.push_back(owner);
        end
    end

    task automatic step();
        @(negedge CLK);
        #1;
    endtask

    // Waits for either ack; cycles counts steps taken, exceeding ACK_BOUND on timeout.
    task automatic wait_ack(output int cycles);
        cycles = 0;
        do begin
            step();
            cycles++;
        end while (!(cpu_ack || ld_ack) && cycles <= ACK_BOUND);
    endtask

    task automatic test_reset();
        int cyc;
        Reset = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0020; cpu_wdata = 16'h0;
        ld_req  = 1'b1; ld_we  = 1'b0; ld_addr  = 16'h0021; ld_wdata  = 16'h0;
        step();
        step();
        total++;
        if ({cpu_ack, ld_ack, mem_we, mem_re} !== 4'b0) begin
            bad++; $display("[TB] FAIL reset_strobes: got %b expected 0000", {cpu_ack, ld_ack, mem_we, mem_re});
        end
        total++;
        if ({cpu_rdata, ld_rdata} !== 32'h0) begin
            bad++; $display("[TB] FAIL reset_rdata: got %h expected 0", {cpu_rdata, ld_rdata});
        end
        total++;
        if ({mem_addr, mem_wdata} !== 32'h0) begin
            bad++; $display("[TB] FAIL reset_mem_bus: got %h expected 0", {mem_addr, mem_wdata});
        end
        total++;
        if (owner !== 2'b00) begin
            bad++; $display("[TB] FAIL reset_owner: got %b expected 00", owner);
        end
        Reset = 1'b1;
        wait_ack(cyc);
        total++;
        if ({cpu_ack, ld_ack, owner} !== 4'b1001) begin
            bad++; $display("[TB] FAIL first_grant: got ack=%b%b owner=%b expected cpu ack, owner 01",
                            cpu_ack, ld_ack, owner);
        end
        cpu_req = 1'b0;
        ld_req  = 1'b0;
        step();
        step();
    endtask

    task automatic test_c_read();
        int cyc;
        int re0;
        int lack0;
        re0 = re_cnt; lack0 = lack_cnt;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
        wait_ack(cyc);
        total++;
        if (cyc !== MEM_LAT + 1 || cpu_ack !== 1'b1) begin
            bad++; $display("[TB] FAIL c_read_latency: got %0d cycles ack=%b expected %0d ack=1", cyc, cpu_ack, MEM_LAT + 1);
        end
        total++;
        if (re_cnt - re0 !== MEM_LAT) begin
            bad++; $display("[TB] FAIL c_read_re_cycles: got %0d expected %0d", re_cnt - re0, MEM_LAT);
        end
        total++;
        if (cpu_rdata !== 16'h1234) begin
            bad++; $display("[TB] FAIL c_read_data: got %h expected 1234", cpu_rdata);
        end
        total++;
        if (lack_cnt !== lack0) begin
            bad++; $display("[TB] FAIL c_read_ld_ack: got %0d pulses expected 0", lack_cnt - lack0);
        end
        cpu_req = 1'b0;
        step();
    endtask

    task automatic test_l_write();
        int cyc;
        int we0;
        int cack0;
        int lack0;
        we0 = we_cnt; cack0 = cack_cnt; lack0 = lack_cnt;
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 16'h0005; ld_wdata = 16'hBEEF;
        wait_ack(cyc);
        ld_req = 1'b0;
        ref_mem[5] = 16'hBEEF;
        step();
        step();
        total++;
        if (we_cnt - we0 !== 1) begin
            bad++; $display("[TB] FAIL l_write_strobes: got %0d expected 1", we_cnt - we0);
        end
        total++;
        if ({last_we_addr, last_we_data} !== {16'h0005, 16'hBEEF}) begin
            bad++; $display("[TB] FAIL l_write_bus: got %h/%h expected 0005/beef", last_we_addr, last_we_data);
        end
        total++;
        if (lack_cnt - lack0 !== 1 || cack_cnt !== cack0) begin
            bad++; $display("[TB] FAIL l_write_acks: got ld=%0d cpu=%0d expected ld=1 cpu=0",
                            lack_cnt - lack0, cack_cnt - cack0);
        end
    endtask

    task automatic test_burst_limit();
        int base;
        int cyc;
        int burst;
        bit exp_ld;
        base = ack_ld_q.size();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0040;
        ld_req  = 1'b1; ld_we  = 1'b0; ld_addr  = 16'h0041;
        cyc = 0;
        while (ack_ld_q.size() - base < 10 && cyc < 200) begin
            step();
            cyc++;
        end
        cpu_req = 1'b0;
        ld_req  = 1'b0;
        step();
        step();
        total++;
        if (ack_ld_q.size() - base < 10) begin
            bad++; $display("[TB] FAIL burst_timeout: got %0d acks expected 10", ack_ld_q.size() - base);
        end else begin
            burst = 0;
            for (int i = 0; i < 10; i++) begin
                exp_ld = (burst == CPU_BURST_MAX);
                burst  = exp_ld ? 0 : ((burst < CPU_BURST_MAX) ? burst + 1 : burst);
                total++;
                if (ack_ld_q[base + i] !== exp_ld) begin
                    bad++; $display("[TB] FAIL burst_order[%0d]: got ld=%b expected ld=%b", i, ack_ld_q[base + i], exp_ld);
                end
                total++;
                if (ack_owner_q[base + i] !== (exp_ld ? 2'b10 : 2'b01)) begin
                    bad++; $display("[TB] FAIL burst_owner[%0d]: got %b expected %b", i, ack_owner_q[base + i],
                                    exp_ld ? 2'b10 : 2'b01);
                end
            end
        end
        total++;
        if ({cpu_rdata, ld_rdata} !== {ref_mem[8'h40], ref_mem[8'h41]}) begin
            bad++; $display("[TB] FAIL burst_rdata: got %h/%h expected %h/%h", cpu_rdata, ld_rdata,
                            ref_mem[8'h40], ref_mem[8'h41]);
        end
    endtask

    task automatic test_reset_mid_access();
        int cack0;
        cack0 = cack_cnt;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0030;
        step();
        step();
        Reset   = 1'b0;
        cpu_req = 1'b0;
        step();
        total++;
        if ({owner, cpu_ack, mem_re} !== 4'b0000) begin
            bad++; $display("[TB] FAIL midreset_state: got owner=%b ack=%b re=%b expected 00/0/0", owner, cpu_ack, mem_re);
        end
        total++;
        if (cpu_rdata !== 16'h0) begin
            bad++; $display("[TB] FAIL midreset_rdata: got %h expected 0000", cpu_rdata);
        end
        Reset = 1'b1;
        for (int i = 0; i < 4; i++) step();
        total++;
        if (cack_cnt !== cack0) begin
            bad++; $display("[TB] FAIL midreset_no_ack: got %0d acks expected 0", cack_cnt - cack0);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        logic [AW-1:0] a;
        cpu_req = 1'b1; cpu_we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a = AW'($urandom_range(64, 127));
            cpu_addr = a;
            wait_ack(cyc);
            total++;
            if (cyc !== ((i == 0) ? MEM_LAT + 1 : MEM_LAT + 2) || cpu_ack !== 1'b1) begin
                bad++; $display("[TB] FAIL b2b_spacing[%0d]: got %0d ack=%b expected %0d", i, cyc, cpu_ack,
                                (i == 0) ? MEM_LAT + 1 : MEM_LAT + 2);
            end
            total++;
            if (cpu_rdata !== ref_mem[a[7:0]]) begin
                bad++; $display("[TB] FAIL b2b_rdata[%0d]: got %h expected %h", i, cpu_rdata, ref_mem[a[7:0]]);
            end
        end
        cpu_req = 1'b0;
        step();
    endtask

    task automatic test_random();
        int cyc;
        int we0;
        int re0;
        bit use_ld;
        bit is_we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        for (int i = 0; i < 24; i++) begin
            use_ld = 1'($urandom_range(0, 1));
            is_we  = 1'($urandom_range(0, 1));
            a      = AW'($urandom_range(128, 159));
            d      = DW'($urandom);
            we0 = we_cnt; re0 = re_cnt;
            if (use_ld) begin
                ld_req = 1'b1; ld_we = is_we; ld_addr = a; ld_wdata = d;
            end else begin
                cpu_req = 1'b1; cpu_we = is_we; cpu_addr = a; cpu_wdata = d;
            end
            wait_ack(cyc);
            total++;
            if (cyc !== MEM_LAT + 1 || {cpu_ack, ld_ack} !== (use_ld ? 2'b01 : 2'b10)) begin
                bad++; $display("[TB] FAIL rand_ack[%0d]: got %0d cycles acks=%b%b expected %0d port_l=%b",
                                i, cyc, cpu_ack, ld_ack, MEM_LAT + 1, use_ld);
            end
            total++;
            if ((we_cnt - we0) !== (is_we ? 1 : 0) || (re_cnt - re0) !== (is_we ? 0 : MEM_LAT)) begin
                bad++; $display("[TB] FAIL rand_strobes[%0d]: got we=%0d re=%0d for write=%b",
                                i, we_cnt - we0, re_cnt - re0, is_we);
            end
            if (is_we) begin
                ref_mem[a[7:0]] = d;
            end else begin
                total++;
                if ((use_ld ? ld_rdata : cpu_rdata) !== ref_mem[a[7:0]]) begin
                    bad++; $display("[TB] FAIL rand_rdata[%0d]: got %h expected %h", i,
                                    use_ld ? ld_rdata : cpu_rdata, ref_mem[a[7:0]]);
                end
            end
            cpu_req = 1'b0;
            ld_req  = 1'b0;
            step();
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) step();
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        we_cnt = 0; re_cnt = 0; cack_cnt = 0; lack_cnt = 0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        test_reset();
        test_c_read();
        test_l_write();
        test_burst_limit();
        test_reset_mid_access();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
